// File: rtl/egr_drop_ctl_if.sv
// Handshake bundle between the egress drop controller, its upstream source and the TX FIFO.
// The slave view is the controller; the master view is whatever drives it.
interface egr_drop_ctl_if #(
    parameter int DW = 64
);
    logic          c_srdy;
    logic          c_drdy;
    logic [DW-1:0] c_data;
    logic [1:0]    c_pcc;
    logic          p_srdy;
    logic          p_drdy;
    logic [DW-1:0] p_data;
    logic          p_commit;
    logic          p_abort;

    modport master (
        output c_srdy, c_data, c_pcc, p_drdy,
        input  c_drdy, p_srdy, p_data, p_commit, p_abort
    );

    modport slave (
        input  c_srdy, c_data, c_pcc, p_drdy,
        output c_drdy, p_srdy, p_data, p_commit, p_abort
    );
endinterface

// File: rtl/egr_drop_ctl.sv
// Egress drop controller: forwards whole packets into the TX FIFO or drops them when it is full.
// Optional statistics counters are built only when EGR_DROP_STATS_EN is defined.
module egr_drop_ctl #(
    parameter int DW     = 64,
    parameter int USG_SZ = 8,
    parameter int CNT_SZ = 16
) (
    input  logic              clk,
    input  logic              reset,
    egr_drop_ctl_if.slave     bus,
    input  logic [USG_SZ-1:0] tx_usage,
    input  logic [USG_SZ-1:0] drop_thr,
    input  logic              stat_clr,
    output logic [CNT_SZ-1:0] cnt_ok,
    output logic [CNT_SZ-1:0] cnt_drop,
    output logic [CNT_SZ-1:0] cnt_bad,
    output logic [CNT_SZ-1:0] cnt_orphan
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] PACKET = 2'd1;
    localparam logic [1:0] FLUSH  = 2'd2;

    localparam logic [1:0] PCC_DATA = 2'd0;
    localparam logic [1:0] PCC_SOP  = 2'd1;
    localparam logic [1:0] PCC_EOP  = 2'd2;
    localparam logic [1:0] PCC_BAD  = 2'd3;

    logic [1:0] state, nxt_state;
    logic       full;
    logic       is_sop, is_eop, is_bad, is_data;
    logic       inc_ok, inc_drop, inc_bad, inc_orphan;

    // drop_thr of zero makes every comparison true, so every packet is dropped.
    assign full    = (tx_usage >= drop_thr);
    assign is_sop  = (bus.c_pcc == PCC_SOP);
    assign is_eop  = (bus.c_pcc == PCC_EOP);
    assign is_bad  = (bus.c_pcc == PCC_BAD);
    assign is_data = (bus.c_pcc == PCC_DATA);

    assign bus.p_data = bus.c_data;

    always_comb begin
        nxt_state    = state;
        bus.c_drdy   = 1'b0;
        bus.p_srdy   = 1'b0;
        bus.p_commit = 1'b0;
        bus.p_abort  = 1'b0;
        inc_ok       = 1'b0;
        inc_drop     = 1'b0;
        inc_bad      = 1'b0;
        inc_orphan   = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (bus.c_srdy) begin
                        if (!is_sop) begin
                            bus.c_drdy = 1'b1;
                            inc_orphan = 1'b1;
                        end else if (full) begin
                            bus.c_drdy = 1'b1;
                            inc_drop   = 1'b1;
                            nxt_state  = FLUSH;
                        end else begin
                            // Offer the SOP; it moves only once the FIFO accepts it.
                            bus.p_srdy = 1'b1;
                            bus.c_drdy = bus.p_drdy;
                            if (bus.p_drdy)
                                nxt_state = PACKET;
                        end
                    end
                end
                PACKET: begin
                    if (bus.c_srdy && is_bad) begin
                        bus.c_drdy  = 1'b1;
                        bus.p_abort = 1'b1;
                        inc_bad     = 1'b1;
                        nxt_state   = IDLE;
                    end else if (bus.c_srdy && is_sop) begin
                        // Missing EOP: kill the open packet, leave the SOP for IDLE.
                        bus.p_abort = 1'b1;
                        inc_bad     = 1'b1;
                        nxt_state   = IDLE;
                    end else if (full) begin
                        bus.p_abort = 1'b1;
                        inc_drop    = 1'b1;
                        nxt_state   = FLUSH;
                    end else if (bus.c_srdy) begin
                        bus.p_srdy = 1'b1;
                        bus.c_drdy = bus.p_drdy;
                        if (bus.p_drdy && is_eop) begin
                            bus.p_commit = 1'b1;
                            inc_ok       = 1'b1;
                            nxt_state    = IDLE;
                        end
                    end
                end
                FLUSH: begin
                    if (bus.c_srdy) begin
                        if (is_sop) begin
                            nxt_state = IDLE;
                        end else begin
                            bus.c_drdy = 1'b1;
                            if (is_eop || is_bad)
                                nxt_state = IDLE;
                        end
                    end
                end
                default: nxt_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= nxt_state;
    end

`ifdef EGR_DROP_STATS_EN
    logic [CNT_SZ-1:0] ok_q, drop_q, bad_q, orphan_q;

    function automatic logic [CNT_SZ-1:0] sat_inc(input logic [CNT_SZ-1:0] v, input logic en);
        logic [CNT_SZ-1:0] one;
        one = {{(CNT_SZ-1){1'b0}}, 1'b1};
        return (en && (v != {CNT_SZ{1'b1}})) ? v + one : v;
    endfunction

    always_ff @(posedge clk) begin
        if (reset || stat_clr) begin
            ok_q     <= '0;
            drop_q   <= '0;
            bad_q    <= '0;
            orphan_q <= '0;
        end else begin
            ok_q     <= sat_inc(ok_q, inc_ok);
            drop_q   <= sat_inc(drop_q, inc_drop);
            bad_q    <= sat_inc(bad_q, inc_bad);
            orphan_q <= sat_inc(orphan_q, inc_orphan);
        end
    end

    assign cnt_ok     = ok_q;
    assign cnt_drop   = drop_q;
    assign cnt_bad    = bad_q;
    assign cnt_orphan = orphan_q;
`else
    logic unused_stats;
    assign unused_stats = ^{stat_clr, inc_ok, inc_drop, inc_bad, inc_orphan};
    assign cnt_ok       = '0;
    assign cnt_drop     = '0;
    assign cnt_bad      = '0;
    assign cnt_orphan   = '0;
`endif

    logic unused_pcc;
    assign unused_pcc = is_data;

    a_strobe_excl: assert property (@(posedge clk) disable iff (reset)
        !(bus.p_commit && bus.p_abort));
    a_flush_quiet: assert property (@(posedge clk) disable iff (reset)
        (state == FLUSH) |-> !(bus.p_srdy || bus.p_commit || bus.p_abort));

endmodule
